// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
//   Instruction-fetch sequencer. Owns the architectural PC and keeps at most
//   one request outstanding to instruction memory. Each fetched word is
//   presented to decode as a valid-qualified bundle (inst, pc, pc4). The
//   bundle is held while decode stalls. Branch redirects from execute are
//   applied, and any response made stale by a redirect is discarded.
//
// Ports
//   clk, arst_n         clock (rising edge), async active-low reset
//   br_taken, br_target redirect pulse and target (target[1:0] ignored)
//   stall               decode not ready; held bundle must stay stable
//   imem_req_*          request channel (valid/ready, addr)
//   imem_rsp_*          response channel (valid, data), one per accepted req
//   if_valid, inst,
//   pc, pc4             bundle to decode
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | one cycle after reset, no request
// REQ    | request for pc_q presented, waiting for ready
// WAIT   | request accepted, waiting for its response
// KILL   | request accepted then redirected; drop its response
// HOLD   | bundle valid to decode, held until consumed or redirected

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_KILL = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        if_valid_d;
  logic [31:0] inst_d, pc_out_d, pc4_d;
  logic [31:0] tgt;

  assign tgt            = {br_target[31:2], 2'b00};
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      if_valid   <= 1'b0;
      inst       <= NOP_INST;
      pc         <= 32'h0;
      pc4        <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid   <= if_valid_d;
      inst       <= inst_d;
      pc         <= pc_out_d;
      pc4        <= pc4_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if_valid_d = if_valid;
    inst_d     = inst;
    pc_out_d   = pc;
    pc4_d      = pc4;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (br_taken) begin
          // With ready low the address can still be retargeted; with ready
          // high the old request is already gone, so its response must die.
          pc_d = tgt;
          if (imem_req_ready) state_d = S_KILL;
        end else if (imem_req_ready) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (br_taken) begin
          pc_d    = tgt;
          state_d = imem_rsp_valid ? S_REQ : S_KILL;
        end else if (imem_rsp_valid) begin
          if_valid_d = 1'b1;
          inst_d     = imem_rsp_data;
          pc_out_d   = fetch_pc_q;
          pc4_d      = fetch_pc_q + 32'd4;
          state_d    = S_HOLD;
        end
      end

      S_KILL: begin
        if (br_taken) pc_d = tgt;
        if (imem_rsp_valid) state_d = S_REQ;
      end

      S_HOLD: begin
        if (br_taken) begin
          if_valid_d = 1'b0;
          inst_d     = NOP_INST;
          pc_d       = tgt;
          state_d    = S_REQ;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        arst_n;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;

  int n_checks = 0;
  int n_pass   = 0;

  // imem model: one-cycle response to each accepted request
  logic        pend;
  logic [31:0] pend_addr;

  if_fetch_ctrl dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .inst           (inst),
    .pc             (pc),
    .pc4            (pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Called at a negedge: drives the response for the coming edge, lets one
  // rising edge pass, and returns at the following negedge.
  task automatic cyc();
    logic        acc;
    logic [31:0] acc_addr;
    imem_rsp_valid = pend;
    imem_rsp_data  = pend ? (pend_addr ^ KEY) : 32'h0;
    acc      = imem_req_valid & imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    br_taken       = 1'b0;
    imem_rsp_valid = 1'b0;
    pend           = acc;
    pend_addr      = acc_addr;
  endtask

  task automatic chk_bundle(input string tag, input logic [31:0] epc);
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'd1);
    chk({tag, "_inst"},  inst, epc ^ KEY);
    chk({tag, "_pc"},    pc,   epc);
    chk({tag, "_pc4"},   pc4,  epc + 32'd4);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] eaddr);
    chk({tag, "_rv"},   {31'h0, imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, imem_req_addr, eaddr);
  endtask

  initial begin
    arst_n         = 1'b0;
    br_taken       = 1'b0;
    br_target      = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pend           = 1'b0;
    pend_addr      = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_if_valid", {31'h0, if_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    arst_n = 1'b1;

    // 1: sequential fetch, one bundle per 3 cycles
    chk("idle_no_req", {31'h0, imem_req_valid}, 32'd0);
    cyc();
    chk_req("req0", 32'h0);
    cyc();
    chk("wait0_no_req", {31'h0, imem_req_valid}, 32'd0);
    chk("wait0_if_valid", {31'h0, if_valid}, 32'd0);
    cyc();
    chk_bundle("hold0", 32'h0);
    chk("hold0_no_req", {31'h0, imem_req_valid}, 32'd0);
    cyc();
    chk("req4_if_valid", {31'h0, if_valid}, 32'd0);
    chk_req("req4", 32'h4);
    cyc();
    cyc();
    chk_bundle("hold4", 32'h4);

    // 2: stall holds the bundle, no request issued
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_bundle("stall", 32'h4);
      chk("stall_no_req", {31'h0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    cyc();
    chk_req("req8", 32'h8);

    // 3: redirect in WAIT together with the response: response dropped
    cyc();
    br_taken  = 1'b1;
    br_target = 32'h0000_0103;
    cyc();
    chk("br_wait_if_valid", {31'h0, if_valid}, 32'd0);
    chk_req("req100", 32'h100);
    cyc();
    cyc();
    chk_bundle("hold100", 32'h100);

    // 4: redirect in HOLD outranks stall
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    cyc();
    stall = 1'b0;
    chk("br_hold_if_valid", {31'h0, if_valid}, 32'd0);
    chk("br_hold_inst", inst, NOP);
    chk_req("req200", 32'h200);
    cyc();
    cyc();
    chk_bundle("hold200", 32'h200);
    cyc();
    chk_req("req204", 32'h204);

    // 5: retarget while ready is low, then wrap of pc4
    imem_req_ready = 1'b0;
    br_taken       = 1'b1;
    br_target      = 32'hFFFF_FFFC;
    cyc();
    chk_req("retarget", 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    cyc();
    cyc();
    chk_bundle("hold_top", 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    cyc();
    chk_req("req_wrap", 32'h0);

    // redirect on the accepting edge: KILL drops the response
    br_taken  = 1'b1;
    br_target = 32'h0000_0300;
    cyc();
    chk("kill_no_req", {31'h0, imem_req_valid}, 32'd0);
    cyc();
    chk("kill_if_valid", {31'h0, if_valid}, 32'd0);
    chk_req("req300", 32'h300);

    // 6: async reset during WAIT
    cyc();
    #2 arst_n = 1'b0;
    #1;
    pend = 1'b0;
    chk("arst_if_valid", {31'h0, if_valid}, 32'd0);
    chk("arst_inst", inst, NOP);
    chk("arst_pc", pc, 32'h0);
    chk("arst_pc4", pc4, 32'h0);
    chk("arst_req_valid", {31'h0, imem_req_valid}, 32'd0);
    chk("arst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    chk("post_rst_idle", {31'h0, imem_req_valid}, 32'd0);
    cyc();
    chk_req("post_rst_req", 32'h0);
    cyc();
    cyc();
    chk_bundle("post_rst_hold", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
